// File: rtl/e1_tx_framer.sv
// rtl/e1_tx_framer.sv - E1 transmit framer: TS0 FAS/NFAS/CRC4 generation and bit serialization
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   tick_i           line bit strobe, one clk wide, at least 3 clk apart
//   in_req_o         one-clk pulse requesting the payload byte at in_frame_o/in_ts_o
//   in_frame_o       frame (0..15) of the requested byte
//   in_ts_o          timeslot of the requested byte
//   in_first_o       requested byte is the first one of a multiframe
//   in_data_i        requested byte, sampled the clk after in_req_o
//   out_bit_o        line bit, MSB of each timeslot first
//   out_valid_o      one-clk pulse, out_bit_o has just been updated
//   out_mf_first_o   with out_valid_o: bit is TS0 bit 1 of frame 0
//   ctrl_mode_mf_i   1: CRC4 multiframe, 0: plain double-frame
//   ctrl_alarm_i     A bit (NFAS bit 3)
//   ctrl_sa_i        Sa4..Sa8 (NFAS bits 4..8), ctrl_sa_i[4] = Sa4
//   ctrl_e_i         E bits, ctrl_e_i[1] in frame 13, ctrl_e_i[0] in frame 15

// Serial CRC-4, x^4 + x + 1, MSB first. crc_next_o is the remainder after
// absorbing bit_i; clr_i restarts the register on the same enable.
module e1_crc4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic       clr_i,
   input  logic       bit_i,
   output logic [3:0] crc_next_o
);
   logic [3:0] crc_q, crc_d;
   logic       fb;

   always_comb begin
      fb         = crc_q[3] ^ bit_i;
      crc_next_o = {crc_q[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
      crc_d      = crc_q;
      if (en_i) crc_d = clr_i ? 4'h0 : crc_next_o;
   end

   always_ff @(posedge clk) begin
      if (rst) crc_q <= 4'h0;
      else     crc_q <= crc_d;
   end
endmodule

module e1_tx_framer #(
   parameter bit TS0_TRANSPARENT = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_i,
   output logic       in_req_o,
   output logic [3:0] in_frame_o,
   output logic [4:0] in_ts_o,
   output logic       in_first_o,
   input  logic [7:0] in_data_i,
   output logic       out_bit_o,
   output logic       out_valid_o,
   output logic       out_mf_first_o,
   input  logic       ctrl_mode_mf_i,
   input  logic       ctrl_alarm_i,
   input  logic [4:0] ctrl_sa_i,
   input  logic [1:0] ctrl_e_i
);
   // Position is that of the bit the next tick will send.
   logic [3:0] frame_q, frame_d;
   logic [4:0] ts_q, ts_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] next_byte_q, next_byte_d;
   logic       out_bit_q, out_bit_d;
   logic       out_valid_q, out_valid_d;
   logic       out_mf_first_q, out_mf_first_d;
   logic       in_req_q, in_req_d;
   logic [3:0] in_frame_q, in_frame_d;
   logic [4:0] in_ts_q, in_ts_d;
   logic       in_first_q, in_first_d;
   logic       cap_q, cap_d;
   logic       boot_q, boot_d;
   logic [3:0] crc_smf_q, crc_smf_d;
   logic       mode_mf_q, mode_mf_d;

   logic       byte_end, frame_end, crc_clr, crc_bit, c_bit, mf_bit;
   logic [3:0] nf, crc_next, crc_sel, req_frame;
   logic [4:0] req_ts, first_ts;
   logic       req_ok;
   logic [7:0] ts0_byte;

   // C-bit positions enter the CRC as zero.
   assign crc_bit = (ts_q == 5'd0 && bit_q == 3'd0 && !frame_q[0]) ? 1'b0 : shreg_q[7];

   e1_crc4 u_crc4 (
      .clk        (clk),
      .rst        (rst),
      .en_i       (tick_i),
      .clr_i      (crc_clr),
      .bit_i      (crc_bit),
      .crc_next_o (crc_next)
   );

   // TS0 of the next frame is built on the tick that sends the last bit of
   // the current frame; at an SMF boundary that bit completes the CRC, so C1
   // comes straight from crc_next and the register restarts for the new SMF.
   always_comb begin
      byte_end  = tick_i && (bit_q == 3'd7);
      frame_end = byte_end && (ts_q == 5'd31);
      nf        = frame_q + 4'd1;
      crc_clr   = frame_end && (nf[2:0] == 3'd0);
      crc_sel   = crc_clr ? crc_next : crc_smf_q;
      crc_smf_d = crc_clr ? crc_next : crc_smf_q;
      mode_mf_d = (frame_end && nf == 4'd0) ? ctrl_mode_mf_i : mode_mf_q;
      c_bit     = crc_sel[2'd3 - nf[2:1]];
      case (nf[3:1])
         3'd2, 3'd4, 3'd5: mf_bit = 1'b1;
         3'd6:             mf_bit = ctrl_e_i[1];
         3'd7:             mf_bit = ctrl_e_i[0];
         default:          mf_bit = 1'b0;
      endcase
      if (TS0_TRANSPARENT)
         ts0_byte = {(mode_mf_d && !nf[0]) ? c_bit : next_byte_q[7], next_byte_q[6:0]};
      else if (nf[0])
         ts0_byte = {mode_mf_d ? mf_bit : 1'b1, 1'b1, ctrl_alarm_i, ctrl_sa_i};
      else
         ts0_byte = {mode_mf_d ? c_bit : 1'b1, 7'b0011011};
   end

   // Byte requests run two timeslots ahead of the serializer.
   always_comb begin
      req_ts     = ts_q + 5'd2;
      req_frame  = (ts_q >= 5'd30) ? nf : frame_q;
      req_ok     = (req_ts != 5'd0) || TS0_TRANSPARENT;
      first_ts   = TS0_TRANSPARENT ? 5'd0 : 5'd1;
      in_req_d   = 1'b0;
      in_frame_d = in_frame_q;
      in_ts_d    = in_ts_q;
      in_first_d = in_first_q;
      boot_d     = 1'b0;
      if (boot_q) begin
         in_req_d   = 1'b1;
         in_frame_d = 4'd0;
         in_ts_d    = 5'd1;
         in_first_d = 1'b1;
      end else if (byte_end && req_ok) begin
         in_req_d   = 1'b1;
         in_frame_d = req_frame;
         in_ts_d    = req_ts;
         in_first_d = (req_frame == 4'd0) && (req_ts == first_ts);
      end
      cap_d       = in_req_q;
      next_byte_d = cap_q ? in_data_i : next_byte_q;
   end

   always_comb begin
      frame_d        = frame_q;
      ts_d           = ts_q;
      bit_d          = bit_q;
      shreg_d        = shreg_q;
      out_bit_d      = out_bit_q;
      out_valid_d    = tick_i;
      out_mf_first_d = tick_i && frame_q == 4'd0 && ts_q == 5'd0 && bit_q == 3'd0;
      if (tick_i) begin
         out_bit_d = shreg_q[7];
         bit_d     = bit_q + 3'd1;
         if (byte_end) begin
            ts_d    = ts_q + 5'd1;
            shreg_d = (ts_q == 5'd31) ? ts0_byte : next_byte_q;
            if (ts_q == 5'd31) frame_d = nf;
         end else begin
            shreg_d = {shreg_q[6:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q        <= 4'd0;
         ts_q           <= 5'd0;
         bit_q          <= 3'd0;
         shreg_q        <= 8'h9B;  // frame 0 FAS, double-frame mode
         next_byte_q    <= 8'h00;
         out_bit_q      <= 1'b0;
         out_valid_q    <= 1'b0;
         out_mf_first_q <= 1'b0;
         in_req_q       <= 1'b0;
         in_frame_q     <= 4'd0;
         in_ts_q        <= 5'd0;
         in_first_q     <= 1'b0;
         cap_q          <= 1'b0;
         boot_q         <= 1'b1;
         crc_smf_q      <= 4'h0;
         mode_mf_q      <= 1'b0;
      end else begin
         frame_q        <= frame_d;
         ts_q           <= ts_d;
         bit_q          <= bit_d;
         shreg_q        <= shreg_d;
         next_byte_q    <= next_byte_d;
         out_bit_q      <= out_bit_d;
         out_valid_q    <= out_valid_d;
         out_mf_first_q <= out_mf_first_d;
         in_req_q       <= in_req_d;
         in_frame_q     <= in_frame_d;
         in_ts_q        <= in_ts_d;
         in_first_q     <= in_first_d;
         cap_q          <= cap_d;
         boot_q         <= boot_d;
         crc_smf_q      <= crc_smf_d;
         mode_mf_q      <= mode_mf_d;
      end
   end

   assign in_req_o       = in_req_q;
   assign in_frame_o     = in_frame_q;
   assign in_ts_o        = in_ts_q;
   assign in_first_o     = in_first_q;
   assign out_bit_o      = out_bit_q;
   assign out_valid_o    = out_valid_q;
   assign out_mf_first_o = out_mf_first_q;
endmodule

// File: tb/tb_e1_tx_framer.sv
// tb/tb_e1_tx_framer.sv - directed self-checking bench for e1_tx_framer
module tb_e1_tx_framer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_i = 1'b0;
   logic       in_req_o, in_first_o;
   logic [3:0] in_frame_o;
   logic [4:0] in_ts_o;
   logic [7:0] in_data_i = 8'h00;
   logic       out_bit_o, out_valid_o, out_mf_first_o;
   logic       ctrl_mode_mf_i = 1'b0;
   logic       ctrl_alarm_i = 1'b0;
   logic [4:0] ctrl_sa_i = 5'h1F;
   logic [1:0] ctrl_e_i = 2'b11;

   int n_cmp = 0;
   int n_fail = 0;
   bit tick_en = 1'b0;
   int tick_gap = 4;
   int pat = 0;
   int resp_mf = -1;
   int resp_fr, resp_ts;

   typedef struct {int fr; int ts; bit first;} req_t;
   req_t req_log[$];
   logic rx_bits[$];
   logic rx_mff[$];

   e1_tx_framer dut (
      .clk            (clk),
      .rst            (rst),
      .tick_i         (tick_i),
      .in_req_o       (in_req_o),
      .in_frame_o     (in_frame_o),
      .in_ts_o        (in_ts_o),
      .in_first_o     (in_first_o),
      .in_data_i      (in_data_i),
      .out_bit_o      (out_bit_o),
      .out_valid_o    (out_valid_o),
      .out_mf_first_o (out_mf_first_o),
      .ctrl_mode_mf_i (ctrl_mode_mf_i),
      .ctrl_alarm_i   (ctrl_alarm_i),
      .ctrl_sa_i      (ctrl_sa_i),
      .ctrl_e_i       (ctrl_e_i)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] payload(int p, int mf, int fr, int ts);
      logic [31:0] h;
      if (p == 0) return ts[7:0];
      if (p == 1) return 8'h00;
      h = 32'(mf * 1103 + fr * 37 + ts * 151 + 17);
      h = h ^ (h >> 5);
      h = h * 32'h9E3779B1;
      return h[31:24];
   endfunction

   function automatic logic [7:0] rx_byte(int k);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = rx_bits[8*k+i];
      return b;
   endfunction

   // line tick generator, tick_gap clk period
   initial forever begin
      @(posedge clk);
      if (tick_en) begin
         #1 tick_i = 1'b1;
         @(posedge clk);
         #1 tick_i = 1'b0;
         repeat (tick_gap - 2) @(posedge clk);
      end
   end

   // upstream: answers each request one clk later
   initial forever begin
      @(negedge clk);
      if (rst) resp_mf = -1;
      else if (in_req_o) begin
         resp_fr = int'(in_frame_o);
         resp_ts = int'(in_ts_o);
         if (in_first_o) resp_mf++;
         req_log.push_back('{resp_fr, resp_ts, in_first_o});
         @(posedge clk);
         #1 in_data_i = payload(pat, resp_mf, resp_fr, resp_ts);
      end
   end

   // line recorder
   initial forever begin
      @(negedge clk);
      if (out_valid_o) begin
         rx_bits.push_back(out_bit_o);
         rx_mff.push_back(out_mf_first_o);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_bits(input int n, input int budget, input string what);
      int c = 0;
      while (rx_bits.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (rx_bits.size() < n) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s timeout: got %0d bits, required %0d", what, rx_bits.size(), n);
      end
   endtask

   task automatic do_reset(input int gap, input int p, input logic mode);
      tick_en = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      tick_gap = gap;
      pat = p;
      ctrl_mode_mf_i = mode;
      ctrl_alarm_i = 1'b0;
      ctrl_sa_i = 5'h1F;
      ctrl_e_i = 2'b11;
      repeat (3) @(posedge clk);
      rx_bits.delete();
      rx_mff.delete();
      req_log.delete();
      #1 rst = 1'b0;
      tick_en = 1'b1;
   endtask

   task automatic test_reset();
      int seen_valid = 0;
      tick_gap = 3;
      tick_en = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      repeat (10) begin
         @(negedge clk);
         if (out_valid_o !== 1'b0) seen_valid++;
      end
      n_cmp++;
      if (seen_valid !== 0) begin n_fail++; $display("FAIL reset_out_valid: %0d pulses, required 0", seen_valid); end
      n_cmp++;
      if (in_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_req: got %b, required 0", in_req_o); end
      n_cmp++;
      if (out_bit_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_bit: got %b, required 0", out_bit_o); end
      n_cmp++;
      if (out_mf_first_o !== 1'b0) begin n_fail++; $display("FAIL reset_mf_first: got %b, required 0", out_mf_first_o); end
      tick_en = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_req_o !== 1'b0) begin n_fail++; $display("FAIL boot_req_early: got %b, required 0", in_req_o); end
      @(negedge clk);
      n_cmp++;
      if ({in_req_o, in_frame_o, in_ts_o, in_first_o} !== {1'b1, 4'd0, 5'd1, 1'b1})
      begin
         n_fail++;
         $display("FAIL boot_req: got req=%b fr=%0d ts=%0d first=%b, required 1/0/1/1",
                  in_req_o, in_frame_o, in_ts_o, in_first_o);
      end
   endtask

   task automatic test_plain();
      int mff = 0;
      logic [7:0] exp;
      do_reset(4, 0, 1'b0);
      wait_bits(512, 4000, "plain");
      for (int k = 0; k < 64; k++) begin
         if (k % 32 == 0) exp = ((k / 32) % 2 == 0) ? 8'h9B : 8'hDF;
         else exp = 8'(k % 32);
         n_cmp++;
         if (rx_byte(k) !== exp) begin
            n_fail++;
            $display("FAIL plain_byte fr=%0d ts=%0d: got %h, required %h", k / 32, k % 32, rx_byte(k), exp);
         end
      end
      n_cmp++;
      if (rx_mff[0] !== 1'b1) begin n_fail++; $display("FAIL plain_mf_first0: got %b, required 1", rx_mff[0]); end
      for (int i = 1; i < 512; i++) if (rx_mff[i] !== 1'b0) mff++;
      n_cmp++;
      if (mff !== 0) begin n_fail++; $display("FAIL plain_mf_first_extra: got %0d, required 0", mff); end
   endtask

   task automatic test_req_timing();
      int cnt = 0;
      int bad = 0;
      int nxt = -1;
      do_reset(3, 0, 1'b0);
      wait_bits(300, 2000, "req_timing");
      for (int i = 0; i < req_log.size(); i++) begin
         if (req_log[i].fr == 0) begin
            if (req_log[i].ts !== cnt + 1 || req_log[i].first !== (cnt == 0)) bad++;
            cnt++;
         end else if (req_log[i].fr == 1 && nxt < 0) nxt = req_log[i].ts;
      end
      n_cmp++;
      if (cnt !== 31) begin n_fail++; $display("FAIL req_count: got %0d, required 31", cnt); end
      n_cmp++;
      if (bad !== 0) begin n_fail++; $display("FAIL req_order: got %0d bad entries, required 0", bad); end
      n_cmp++;
      if (nxt !== 1) begin n_fail++; $display("FAIL req_wrap_ts: got %0d, required 1", nxt); end
      n_cmp++;
      if (rx_byte(31) !== 8'd31) begin n_fail++; $display("FAIL req_ts31_data: got %h, required 1f", rx_byte(31)); end
   endtask

   task automatic test_alarm();
      do_reset(3, 0, 1'b0);
      wait_bits(3 * 256 + 80, 4000, "alarm_pre");
      ctrl_alarm_i = 1'b1;
      ctrl_sa_i = 5'b01010;
      wait_bits(6 * 256, 8000, "alarm_post");
      n_cmp++;
      if (rx_byte(3 * 32) !== 8'hDF) begin n_fail++; $display("FAIL alarm_fr3: got %h, required df", rx_byte(96)); end
      n_cmp++;
      if (rx_byte(4 * 32) !== 8'h9B) begin n_fail++; $display("FAIL alarm_fr4: got %h, required 9b", rx_byte(128)); end
      n_cmp++;
      if (rx_byte(5 * 32) !== 8'hEA) begin n_fail++; $display("FAIL alarm_fr5: got %h, required ea", rx_byte(160)); end
      n_cmp++;
      if (rx_byte(3 * 32 + 10) !== 8'd10) begin n_fail++; $display("FAIL alarm_payload: got %h, required 0a", rx_byte(106)); end
   endtask

   task automatic test_mf_crc();
      localparam int NB = 40 * 32;
      logic [7:0] exp_b [0:NB-1];
      logic [3:0] smf_c [0:4];
      logic [3:0] crc = 4'h0;
      logic [3:0] prevc = 4'h0;
      logic [7:0] mft = 8'hF4;
      logic [7:0] b;
      logic [3:0] got_c;
      logic       md, fb, bt;
      logic       seq [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      int mf, fr, ts, nbad;
      do_reset(3, 2, 1'b1);
      for (int k = 0; k < NB; k++) begin
         mf = k / 512;
         fr = (k / 32) % 16;
         ts = k % 32;
         md = (mf > 0);
         if (ts == 0 && fr % 8 == 0) begin
            prevc = crc;
            crc = 4'h0;
            smf_c[k / 256] = prevc;
         end
         if (ts == 0 && fr % 2 == 0) b = {md ? prevc[3 - (fr / 2) % 4] : 1'b1, 7'b0011011};
         else if (ts == 0) b = {md ? mft[fr / 2] : 1'b1, 1'b1, 1'b0, 5'h1F};
         else b = payload(2, mf, fr, ts);
         exp_b[k] = b;
         for (int i = 7; i >= 0; i--) begin
            bt = (ts == 0 && i == 7 && fr % 2 == 0) ? 1'b0 : b[i];
            fb = crc[3] ^ bt;
            crc = {crc[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
         end
      end
      wait_bits(NB * 8, 40000, "mf_crc");
      nbad = 0;
      for (int k = 0; k < NB; k++) begin
         n_cmp++;
         if (rx_byte(k) !== exp_b[k]) begin
            n_fail++;
            nbad++;
            if (nbad < 20)
               $display("FAIL mf_byte k=%0d fr=%0d ts=%0d: got %h, required %h",
                        k, (k / 32) % 16, k % 32, rx_byte(k), exp_b[k]);
         end
      end
      for (int j = 0; j < 8; j++) begin
         n_cmp++;
         if (rx_bits[8 * (512 + (2 * j + 1) * 32)] !== seq[j]) begin
            n_fail++;
            $display("FAIL mf_bit fr=%0d: got %b, required %b", 2 * j + 1,
                     rx_bits[8 * (512 + (2 * j + 1) * 32)], seq[j]);
         end
      end
      for (int s = 2; s < 5; s++) begin
         for (int c = 0; c < 4; c++) got_c[3 - c] = rx_bits[8 * (s * 256 + c * 64)];
         n_cmp++;
         if (got_c !== smf_c[s]) begin
            n_fail++;
            $display("FAIL crc_c smf=%0d: got %h, required %h", s, got_c, smf_c[s]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int seen_valid = 0;
      logic [7:0] first;
      do_reset(3, 0, 1'b0);
      wait_bits((9 * 32 + 17) * 8 + 4, 10000, "reset_mid");
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      repeat (10) begin
         @(negedge clk);
         if (out_valid_o !== 1'b0) seen_valid++;
      end
      n_cmp++;
      if (seen_valid !== 0) begin n_fail++; $display("FAIL rstmid_valid: %0d pulses, required 0", seen_valid); end
      rx_bits.delete();
      rx_mff.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      wait_bits(8, 200, "reset_mid_restart");
      n_cmp++;
      if (rx_mff[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_mf_first: got %b, required 1", rx_mff[0]); end
      first = rx_byte(0);
      n_cmp++;
      if (first !== 8'h9B) begin n_fail++; $display("FAIL rstmid_ts0: got %h, required 9b", first); end
   endtask

   initial begin
      test_reset();
      test_plain();
      test_req_timing();
      test_alarm();
      test_mf_crc();
      test_reset_mid();
      tick_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
